// File: rtl/srambank_pkg.sv
// Shared types and helpers for the SRAM bank initiator and its response FIFO.
// rsp_entry_t is sized for the default TAG/DATA widths.
package srambank_pkg;

  localparam int unsigned RSP_DATA_W = 18;
  localparam int unsigned RSP_TAG_W  = 4;

  typedef struct packed {
    logic [RSP_TAG_W-1:0]  tag;
    logic [RSP_DATA_W-1:0] data;
  } rsp_entry_t;

  function automatic int unsigned bank_bits(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic bank_hit(input int unsigned idx, input int unsigned bank);
    return idx == bank;
  endfunction

endpackage

// File: rtl/srambank_rsp_fifo.sv
// In-order response FIFO with occupancy output; reads back zero when empty.
// Depth must be a power of two so the pointers wrap naturally.
module srambank_rsp_fifo import srambank_pkg::*; #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = ptr_bits(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop;

  assign o_valid = (count_q != '0);
  assign pop     = i_pop && o_valid;
  assign o_data  = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_count = count_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (i_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({i_push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/srambank_initiator.sv
// Request-side master for a group of single-port SRAM banks with in-order tagged responses.
// Optional feature: define SRAMBANK_INITIATOR_WRITE_ACK_EN to return an ack entry for every write.
module srambank_initiator import srambank_pkg::*; #(
  parameter int unsigned ADDRESS   = 9,
  parameter int unsigned DATA      = RSP_DATA_W,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned TAG       = RSP_TAG_W,
  parameter int unsigned RSP_DEPTH = 4,
  localparam int unsigned BANK_BITS = bank_bits(NUM_BANKS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic                         i_req_write,
  input  logic [ADDRESS+BANK_BITS-1:0] i_req_addr,
  input  logic [DATA-1:0]              i_req_wdata,
  input  logic [TAG-1:0]               i_req_tag,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [DATA-1:0]              o_rsp_data,
  output logic [TAG-1:0]               o_rsp_tag,
  output logic [ADDRESS-1:0]           o_bank_address,
  output logic [DATA-1:0]              o_bank_wdata,
  output logic [NUM_BANKS-1:0]         o_bank_sel,
  output logic                         o_bank_read_en,
  output logic                         o_bank_write_en,
  input  logic [NUM_BANKS*DATA-1:0]    i_bank_rdata
);

  localparam int unsigned CNT_W   = ptr_bits(RSP_DEPTH) + 1;
  localparam int unsigned ENTRY_W = TAG + DATA;

  logic [BANK_BITS-1:0] req_bank;
  logic [ADDRESS-1:0]   req_word;
  logic                 credit_ok;
  logic                 accept;
  logic                 track;
  logic [CNT_W-1:0]     rsp_count;
  logic                 rsp_pop;
  logic [ENTRY_W-1:0]   push_entry;
  logic [ENTRY_W-1:0]   head_entry;
  logic [DATA-1:0]      pend_rdata;

  logic                 pending_q;
  logic                 pend_write_q;
  logic [BANK_BITS-1:0] pend_bank_q;
  logic [TAG-1:0]       pend_tag_q;

  assign req_bank = i_req_addr[BANK_BITS-1:0];
  assign req_word = i_req_addr[BANK_BITS +: ADDRESS];

  // The in-flight entry holds a slot; a same-cycle pop does not free one, keeping ready shallow.
  assign credit_ok = ({1'b0, rsp_count} + {{CNT_W{1'b0}}, pending_q}) < (CNT_W + 1)'(RSP_DEPTH);

`ifdef SRAMBANK_INITIATOR_WRITE_ACK_EN
  assign o_req_ready = i_rst_n && credit_ok;
  assign track       = accept;
`else
  assign o_req_ready = i_rst_n && (i_req_write || credit_ok);
  assign track       = accept && !i_req_write;
`endif

  assign accept = i_req_valid && o_req_ready;

  always_comb begin
    o_bank_address  = '0;
    o_bank_wdata    = '0;
    o_bank_read_en  = 1'b0;
    o_bank_write_en = 1'b0;
    if (accept) begin
      o_bank_address  = req_word;
      o_bank_wdata    = i_req_wdata;
      o_bank_read_en  = !i_req_write;
      o_bank_write_en = i_req_write;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_sel
    assign o_bank_sel[b] = accept && bank_hit(32'(req_bank), b);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pending_q    <= 1'b0;
      pend_write_q <= 1'b0;
      pend_bank_q  <= '0;
      pend_tag_q   <= '0;
    end else begin
      pending_q <= track;
      if (track) begin
        pend_write_q <= i_req_write;
        pend_bank_q  <= req_bank;
        pend_tag_q   <= i_req_tag;
      end
    end
  end

  // Bank output is valid the cycle after the read strobe and held until the next read.
  assign pend_rdata = i_bank_rdata[pend_bank_q * DATA +: DATA];
  assign push_entry = {pend_tag_q, pend_write_q ? {DATA{1'b0}} : pend_rdata};
  assign rsp_pop    = o_rsp_valid && i_rsp_ready;

  srambank_rsp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (pending_q),
    .i_data  (push_entry),
    .i_pop   (rsp_pop),
    .o_valid (o_rsp_valid),
    .o_data  (head_entry),
    .o_count (rsp_count)
  );

  assign o_rsp_tag  = head_entry[ENTRY_W-1 -: TAG];
  assign o_rsp_data = head_entry[DATA-1:0];

endmodule

// File: tb/tb_srambank_initiator.sv
// Scoreboard bench for srambank_initiator with four behavioural single-port SRAM banks.
module tb_srambank_initiator;
  import srambank_pkg::*;

  localparam int ADDRESS   = 9;
  localparam int DATA      = 18;
  localparam int NUM_BANKS = 4;
  localparam int TAG       = 4;
  localparam int RSP_DEPTH = 4;
  localparam int AW        = ADDRESS + 2;
`ifdef SRAMBANK_INITIATOR_WRITE_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      req_valid, req_ready, req_write;
  logic [AW-1:0]             req_addr;
  logic [DATA-1:0]           req_wdata;
  logic [TAG-1:0]            req_tag;
  logic                      rsp_valid, rsp_ready;
  logic [DATA-1:0]           rsp_data;
  logic [TAG-1:0]            rsp_tag;
  logic [ADDRESS-1:0]        bank_address;
  logic [DATA-1:0]           bank_wdata;
  logic [NUM_BANKS-1:0]      bank_sel;
  logic                      bank_read_en, bank_write_en;
  logic [NUM_BANKS*DATA-1:0] bank_rdata;

  always #5 clk = ~clk;

  srambank_initiator #(
    .ADDRESS   (ADDRESS),
    .DATA      (DATA),
    .NUM_BANKS (NUM_BANKS),
    .TAG       (TAG),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_write     (req_write),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .i_req_tag       (req_tag),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_data      (rsp_data),
    .o_rsp_tag       (rsp_tag),
    .o_bank_address  (bank_address),
    .o_bank_wdata    (bank_wdata),
    .o_bank_sel      (bank_sel),
    .o_bank_read_en  (bank_read_en),
    .o_bank_write_en (bank_write_en),
    .i_bank_rdata    (bank_rdata)
  );

  // Banks: registered read, write priority, output held between reads.
  logic [DATA-1:0] bank_mem [NUM_BANKS][1 << ADDRESS];
  logic [DATA-1:0] bank_q   [NUM_BANKS];

  always @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel[b] && bank_write_en) bank_mem[b][bank_address] <= bank_wdata;
      else if (bank_sel[b] && bank_read_en) bank_q[b] <= bank_mem[b][bank_address];
    end
  end

  always_comb begin
    bank_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) bank_rdata[b*DATA +: DATA] = bank_q[b];
  end

  rsp_entry_t      exp_q[$];
  logic [DATA-1:0] ref_mem [1 << AW];
  int              total = 0;
  int              bad = 0;
  int              rsp_seen = 0;
  int              exp_pushed = 0;
  int              stall_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor samples mid-low-phase, after the driver has settled its inputs.
  always @(negedge clk) begin
    #3;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got tag %0h data %0h want no response", rsp_tag, rsp_data);
      end else begin
        rsp_entry_t e;
        e = exp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      end
      rsp_seen++;
    end
  end

  task automatic send(input bit wr, input logic [AW-1:0] addr, input logic [DATA-1:0] data,
                      input logic [TAG-1:0] tag, input bit exp_rsp, input int max_wait,
                      output bit ok);
    int waited;
    logic [NUM_BANKS-1:0] exp_sel;
    rsp_entry_t e;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    req_tag   = tag;
    #1;
    while (!req_ready && waited < max_wait) begin
      @(negedge clk);
      #1;
      waited++;
    end
    stall_cycles += waited;
    if (!req_ready) begin
      ok = 1'b0;
      req_valid = 1'b0;
      return;
    end
    ok = 1'b1;
    exp_sel = NUM_BANKS'(1) << addr[1:0];
    check("bank_sel", 32'(bank_sel), 32'(exp_sel));
    check("bank_address", 32'(bank_address), 32'(addr[AW-1:2]));
    check("bank_write_en", 32'(bank_write_en), 32'(wr));
    check("bank_read_en", 32'(bank_read_en), 32'(!wr));
    if (wr) begin
      check("bank_wdata", 32'(bank_wdata), 32'(data));
      ref_mem[addr] = data;
      if (ACK_EN && exp_rsp) begin
        e = '{tag: tag, data: '0};
        exp_q.push_back(e);
        exp_pushed++;
      end
    end else if (exp_rsp) begin
      e = '{tag: tag, data: ref_mem[addr]};
      exp_q.push_back(e);
      exp_pushed++;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d responses outstanding want 0", exp_q.size());
    end
    @(negedge clk);
    #4;
  endtask

  initial begin
    bit ok;
    int acc;
    int base;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_bank_sel", 32'(bank_sel), 0);
    check("reset_strobes", 32'({bank_read_en, bank_write_en}), 0);
    check("reset_rsp_data", 32'(rsp_data), 0);
    check("reset_rsp_tag", 32'(rsp_tag), 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(req_ready), 1);

    // Preload addresses 0..7 (banks 0..3, words 0..1).
    for (int i = 0; i < 8; i++) begin
      send(1'b1, AW'(i), DATA'(18'h01000 + i * 18'h111), TAG'(i), 1'b1, 4, ok);
      check("preload_accept", 32'(ok), 1);
    end
    idle();
    drain();

    // Write then immediate read of the same word; response lands two edges after the read.
    send(1'b1, AW'(11'h005), 18'h2AAAA, 4'd3, 1'b1, 4, ok);
    send(1'b0, AW'(11'h005), '0, 4'd7, 1'b1, 0, ok);
    check("rdaw_accept", 32'(ok), 1);
    idle();
    #1;
    check("read_latency_n1_valid", 32'(rsp_valid), 32'(ACK_EN));
    @(negedge clk);
    #4;
    check("read_latency_n2_valid", 32'(rsp_valid), 1);
    check("read_latency_n2_tag", 32'(rsp_tag), 7);
    drain();

    // Eight back-to-back reads with a free response path.
    stall_cycles = 0;
    base = rsp_seen;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, AW'(i), '0, TAG'(i + 8), 1'b1, 0, ok);
      if (ok) acc++;
    end
    check("b2b_accepted", 32'(acc), 8);
    check("b2b_stalls", 32'(stall_cycles), 0);
    idle();
    @(negedge clk);
    #4;
    check("b2b_rsp_per_cycle", 32'(rsp_seen - base), 8);
    drain();

    // Blocked response path: credit admits exactly RSP_DEPTH reads.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(1'b0, AW'(i), '0, TAG'(i), 1'b1, 2, ok);
      if (ok) acc++;
    end
    check("blocked_accepted", 32'(acc), RSP_DEPTH);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    #1;
    check("blocked_read_ready", 32'(req_ready), 0);
    req_write = 1'b1;
    #1;
    check("blocked_write_ready", 32'(req_ready), 32'(!ACK_EN));
`ifndef SRAMBANK_INITIATOR_WRITE_ACK_EN
    send(1'b1, AW'(6), 18'h15555, 4'd9, 1'b1, 0, ok);
    check("blocked_write_accept", 32'(ok), 1);
`endif
    idle();
    drain();

    // Fill three slots plus one in flight, then release: push and pop coincide.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, AW'(i + 2), '0, TAG'(i + 1), 1'b1, 0, ok);
      if (ok) acc++;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, AW'(7 - i), '0, TAG'(i + 11), 1'b1, 3, ok);
      if (ok) acc++;
    end
    check("pushpop_accepted", 32'(acc), 8);
    idle();
    drain();

    // Reset one cycle after a read accept drops the read.
    send(1'b0, AW'(3), '0, 4'd5, 1'b0, 0, ok);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_drop_valid", 32'(rsp_valid), 0);
    check("rst_drop_strobes", 32'({bank_sel, bank_read_en, bank_write_en}), 0);
    repeat (3) begin
      @(negedge clk);
      #4;
      check("rst_drop_no_rsp", 32'(rsp_valid), 0);
    end

`ifdef SRAMBANK_INITIATOR_WRITE_ACK_EN
    // Write acks interleave in order with surrounding reads.
    send(1'b0, AW'(1), '0, 4'd1, 1'b1, 4, ok);
    send(1'b1, AW'(2), 18'h0BEEF, 4'd2, 1'b1, 4, ok);
    send(1'b0, AW'(2), '0, 4'd3, 1'b1, 4, ok);
    idle();
    drain();
`endif

    drain();
    check("all_rsp_seen", 32'(rsp_seen), 32'(exp_pushed));
    check("end_rsp_valid", 32'(rsp_valid), 0);
    check("end_empty_data", 32'({rsp_tag, rsp_data}), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
